// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI secondary block.
package spi_pkg;
    localparam int SPI_DWIDTH_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam logic [1:0] SPI_MODE0 = 2'b00;   // {CPOL, CPHA}

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises cs/sclk/mosi into the clk domain and derives cs/sclk edges.
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sclk,
    input  logic mosi,
    output logic cs_s,
    output logic sclk_s,
    output logic mosi_s,
    output logic cs_fall,
    output logic cs_rise,
    output logic sclk_rise,
    output logic sclk_fall
);
    // Bit order per stage: {mosi, sclk, cs}; idle is cs high, sclk low.
    localparam logic [2:0] PIN_IDLE = 3'b001;

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [1:0]                  prev_q, prev_d;

    always_comb begin
        sync_d[0] = {mosi, sclk, cs};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = sync_q[SYNC_STAGES-1][1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{PIN_IDLE}};
            prev_q <= PIN_IDLE[1:0];
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign cs_s      = sync_q[SYNC_STAGES-1][0];
    assign sclk_s    = sync_q[SYNC_STAGES-1][1];
    assign mosi_s    = sync_q[SYNC_STAGES-1][2];
    assign cs_fall   =  prev_q[0] & ~cs_s;
    assign cs_rise   = ~prev_q[0] &  cs_s;
    assign sclk_rise = ~prev_q[1] &  sclk_s;
    assign sclk_fall =  prev_q[1] & ~sclk_s;
endmodule

// File: rtl/spi_secondary.sv
// SPI mode-0 secondary: oversampled pins, one-word TX buffer and RX holding register.
module spi_secondary
    import spi_pkg::*;
#(
    parameter int DWIDTH      = SPI_DWIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              done,
    output logic              rx_full,
    output logic              tx_empty,
    output logic              ovr,
    output logic              udr,
    output logic              busy,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso
);
    localparam int BW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(DWIDTH - 1);

    logic cs_s, sclk_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_s      (cs_s),
        .sclk_s    (sclk_s),
        .mosi_s    (mosi_s),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    spi_state_e        state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DWIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [DWIDTH-1:0] tx_buf_q, tx_buf_d, dout_q, dout_d;
    logic              tx_empty_q, tx_empty_d, rx_full_q, rx_full_d;
    logic              done_q, done_d, ovr_q, ovr_d, udr_q, udr_d, miso_q, miso_d;
    logic              reload;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        tx_buf_d   = tx_buf_q;
        dout_d     = dout_q;
        tx_empty_d = tx_empty_q;
        rx_full_d  = rx_full_q;
        miso_d     = miso_q;
        done_d     = 1'b0;
        ovr_d      = 1'b0;
        udr_d      = 1'b0;
        reload     = 1'b0;

        // A completion below overrides this clear, so rd never loses a fresh word.
        if (rd) rx_full_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_sh_d = {rx_sh_q[DWIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST) begin
                        dout_d    = rx_sh_d;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        rx_full_d = 1'b1;
                        ovr_d     = rx_full_q & ~rd;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        reload = 1'b1;
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                        miso_d  = tx_sh_d[DWIDTH-1];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reload reads the old buffer; a same-cycle wr lands afterwards and stays buffered.
        if (reload) begin
            if (tx_empty_q) begin
                tx_sh_d = '0;
                udr_d   = 1'b1;
            end else begin
                tx_sh_d    = tx_buf_q;
                tx_empty_d = 1'b1;
            end
            miso_d = tx_sh_d[DWIDTH-1];
        end

        if (wr) begin
            tx_buf_d   = din;
            tx_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            tx_buf_q   <= '0;
            dout_q     <= '0;
            tx_empty_q <= 1'b1;
            rx_full_q  <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            udr_q      <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            tx_buf_q   <= tx_buf_d;
            dout_q     <= dout_d;
            tx_empty_q <= tx_empty_d;
            rx_full_q  <= rx_full_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            udr_q      <= udr_d;
            miso_q     <= miso_d;
        end
    end

    assign dout     = dout_q;
    assign done     = done_q;
    assign rx_full  = rx_full_q;
    assign tx_empty = tx_empty_q;
    assign ovr      = ovr_q;
    assign udr      = udr_q;
    assign busy     = ~cs_s;
    assign miso     = miso_q;
endmodule

// File: tb/tb_spi_secondary.sv
// Directed bench for spi_secondary: a behavioural mode-0 master at sclk = clk/8.
module tb_spi_secondary;
    logic       clk = 1'b0;
    logic       rst, wr, rd, cs, sclk, mosi;
    logic [7:0] din, dout;
    logic       done, rx_full, tx_empty, ovr, udr, busy, miso;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, ovr_cnt = 0, udr_cnt = 0;
    int d0, o0, u0;
    logic [7:0] mi, w;

    spi_secondary dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout),
        .done(done), .rx_full(rx_full), .tx_empty(tx_empty), .ovr(ovr),
        .udr(udr), .busy(busy), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (ovr)  ovr_cnt  <= ovr_cnt + 1;
        if (udr)  udr_cnt  <= udr_cnt + 1;
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        d0 = done_cnt; o0 = ovr_cnt; u0 = udr_cnt;
    endtask

    task automatic host_wr(input logic [7:0] v);
        din = v; wr = 1'b1; nclk(1); wr = 1'b0;
    endtask

    task automatic host_rd();
        rd = 1'b1; nclk(1); rd = 1'b0;
    endtask

    // n bits MSB first; sclk is left high. rd_end pulses rd on the completion clk of the last bit.
    task automatic shift_bits(input logic [7:0] mo, input int n, input bit rd_end,
                              output logic [7:0] mi_o);
        mi_o = '0;
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0; mosi = mo[i];
            nclk(4);
            sclk = 1'b1; mi_o[i] = miso;
            if (rd_end && i == 0) begin
                nclk(2); rd = 1'b1; nclk(1); rd = 1'b0; nclk(1);
            end else begin
                nclk(4);
            end
        end
    endtask

    task automatic frame_start();
        cs = 1'b0; nclk(6);
    endtask

    task automatic frame_end();
        sclk = 1'b0; nclk(4); cs = 1'b1; nclk(6);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        nclk(3);
        chk("rst_dout", dout, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_rx_full", rx_full, 1'b0);
        chk("rst_tx_empty", tx_empty, 1'b1);
        chk("rst_ovr_udr", {ovr, udr}, 2'b00);
        chk("rst_busy_miso", {busy, miso}, 2'b00);
        rst = 1'b0; nclk(3);

        // 1: basic word exchange
        host_wr(8'hA5);
        chk("t1_tx_empty_wr", tx_empty, 1'b0);
        snap();
        frame_start();
        chk("t1_tx_empty_cs", tx_empty, 1'b1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_miso_msb", miso, 1'b1);
        shift_bits(8'h3C, 8, 1'b0, mi);
        chk("t1_master_rx", mi, 8'hA5);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_udr_cnt", udr_cnt - u0, 0);
        chk("t1_dout", dout, 8'h3C);
        chk("t1_rx_full", rx_full, 1'b1);
        frame_end();
        chk("t1_idle_busy_miso", {busy, miso}, 2'b00);
        host_rd();
        chk("t1_rd_clears", rx_full, 1'b0);

        // 2: underflow sends zeros
        snap();
        frame_start();
        chk("t2_udr_at_cs", udr_cnt - u0, 1);
        shift_bits(8'h96, 8, 1'b0, mi);
        chk("t2_master_rx", mi, 8'h00);
        chk("t2_udr_cnt", udr_cnt - u0, 1);
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_dout", dout, 8'h96);
        frame_end();
        host_rd();

        // 3: back-to-back words, second wr after cs fall, no rd
        host_wr(8'h11);
        snap();
        frame_start();
        host_wr(8'h22);
        shift_bits(8'h81, 8, 1'b0, mi);
        chk("t3_master_rx0", mi, 8'h11);
        chk("t3_dout0", dout, 8'h81);
        chk("t3_ovr0", ovr_cnt - o0, 0);
        shift_bits(8'h42, 8, 1'b0, mi);
        chk("t3_master_rx1", mi, 8'h22);
        chk("t3_done_cnt", done_cnt - d0, 2);
        chk("t3_ovr_cnt", ovr_cnt - o0, 1);
        chk("t3_dout1", dout, 8'h42);
        frame_end();
        host_rd();

        // 4: partial word aborted by cs rise
        snap();
        frame_start();
        shift_bits(8'hF0, 5, 1'b0, mi);
        frame_end();
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_dout_kept", dout, 8'h42);
        chk("t4_bit_cnt", dut.bit_cnt_q, 0);
        host_wr(8'hC3);
        frame_start();
        shift_bits(8'h9E, 8, 1'b0, mi);
        chk("t4_master_rx", mi, 8'hC3);
        chk("t4_dout_next", dout, 8'h9E);
        frame_end();
        host_rd();

        // 5a: rd coincident with completion while rx_full already set
        snap();
        frame_start();
        shift_bits(8'h0F, 8, 1'b0, mi);
        chk("t5a_rx_full_pre", rx_full, 1'b1);
        shift_bits(8'hE7, 8, 1'b1, mi);
        chk("t5a_rx_full", rx_full, 1'b1);
        chk("t5a_no_ovr", ovr_cnt - o0, 0);
        chk("t5a_dout", dout, 8'hE7);
        frame_end();
        host_rd();

        // 5b: wr coincident with the cs-fall reload
        host_wr(8'h5A);
        cs = 1'b0;
        nclk(2); din = 8'h77; wr = 1'b1; nclk(1); wr = 1'b0; nclk(3);
        chk("t5b_tx_empty", tx_empty, 1'b0);
        shift_bits(8'h01, 8, 1'b0, mi);
        chk("t5b_old_word", mi, 8'h5A);
        shift_bits(8'h02, 8, 1'b0, mi);
        chk("t5b_new_word", mi, 8'h77);
        frame_end();
        host_rd();

        // 6: reset mid-frame, then a clean frame
        host_wr(8'h33);
        frame_start();
        shift_bits(8'hFF, 3, 1'b0, mi);
        rst = 1'b1; nclk(1);
        chk("t6_dout", dout, 8'h00);
        chk("t6_flags", {done, rx_full, tx_empty, ovr, udr, busy, miso}, 7'b0010000);
        chk("t6_bit_cnt", dut.bit_cnt_q, 0);
        cs = 1'b1; sclk = 1'b0; nclk(2);
        rst = 1'b0; nclk(4);
        host_wr(8'h6C);
        frame_start();
        shift_bits(8'hB1, 8, 1'b0, mi);
        chk("t6_master_rx", mi, 8'h6C);
        chk("t6_dout", dout, 8'hB1);
        frame_end();
        host_rd();

        // Random words, one per frame
        for (int k = 0; k < 12; k++) begin
            w = 8'($urandom_range(0, 255));
            host_wr(8'(~w + 8'(k)));
            frame_start();
            shift_bits(w, 8, 1'b0, mi);
            chk("rnd_master_rx", mi, 8'(~w + 8'(k)));
            chk("rnd_dout", dout, w);
            frame_end();
            host_rd();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
